pc_sequencer: RTL and testbench

- Program-counter and control-flow sequencer for the PIC16F core; the block directly upstream of hardware_stack.
- Owns the 13-bit fetch PC and drives the stack's push/pop/in ports; consumes the stack's top-of-stack output on returns.
- Applies the PIC two-stage fetch/execute rule: any taken control transfer turns the already-fetched instruction into a bubble (NOP).
- Tracks stack depth for diagnostic overflow/underflow flags. The stack itself still wraps silently.

---
 rtl/pc_sequencer.sv | 157 +++++++++++++++
 tb/tb_pc_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter and control-flow sequencer for the PIC16F core.
//
// Owns the fetch PC and drives the hardware_stack push/pop/in ports. Models the
// two-stage fetch/execute pipeline. Any taken control transfer turns the
// already-fetched instruction into a bubble.
//
// Ports:
//   clk, rst       core clock (rising edge), synchronous active-high reset
//   ce             instruction-slot advance strobe; state changes only when high
//   op_call/op_goto/op_return/skip_taken/pcl_we
//                  decoded control-flow actions of the executing instruction
//   pcl_wdata      data written to PCL
//   pclath         current PCLATH value
//   lit_k          CALL/GOTO literal
//   stack_top      hardware_stack top-of-stack output
//   pc, pcl_rdata  fetch address and its low byte, used for PCL reads
//   exec_valid     executing slot holds a real instruction (0 = bubble)
//   stack_push/stack_pop/stack_data
//                  hardware_stack controls
//   stack_ovf/stack_unf
//                  sticky diagnostic depth flags; they never block execution
module pc_sequencer #(
    parameter int unsigned PC_WIDTH  = 13,
    parameter int unsigned LIT_WIDTH = 11,
    parameter int unsigned TOS_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  op_call,
    input  logic                  op_goto,
    input  logic                  op_return,
    input  logic                  skip_taken,
    input  logic                  pcl_we,
    input  logic [7:0]            pcl_wdata,
    input  logic [PC_WIDTH-9:0]   pclath,
    input  logic [LIT_WIDTH-1:0]  lit_k,
    input  logic [PC_WIDTH-1:0]   stack_top,
    output logic [PC_WIDTH-1:0]   pc,
    output logic [7:0]            pcl_rdata,
    output logic                  exec_valid,
    output logic                  stack_push,
    output logic                  stack_pop,
    output logic [PC_WIDTH-1:0]   stack_data,
    output logic                  stack_ovf,
    output logic                  stack_unf
);

    typedef enum logic [0:0] {
        StBubble,
        StRun
    } state_e;

    localparam logic [PC_WIDTH-1:0]  PcOne    = PC_WIDTH'(1);
    localparam logic [TOS_WIDTH:0]   DepthOne = (TOS_WIDTH + 1)'(1);
    localparam logic [TOS_WIDTH:0]   DepthMax = {1'b1, {TOS_WIDTH{1'b0}}};

    state_e                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [TOS_WIDTH:0]    depth_q, depth_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic [PC_WIDTH-1:0]   pc_inc;
    logic [PC_WIDTH-1:0]   jump_target;
    logic [PC_WIDTH-1:0]   pcl_target;

    assign pc_inc = pc_q + PcOne;
    // CALL/GOTO take only the PCLATH bits above the literal.
    assign jump_target = {pclath[PC_WIDTH-9:LIT_WIDTH-8], lit_k};
    assign pcl_target  = {pclath, pcl_wdata};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        depth_d    = depth_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        stack_push = 1'b0;
        stack_pop  = 1'b0;

        // rst gates the strobe so no push/pop leaks out on a reset edge.
        if (ce && !rst) begin
            case (state_q)
                StBubble: begin
                    pc_d    = pc_inc;
                    state_d = StRun;
                end
                StRun: begin
                    if (op_return) begin
                        stack_pop = 1'b1;
                        pc_d      = stack_top;
                        state_d   = StBubble;
                    end else if (op_call) begin
                        stack_push = 1'b1;
                        pc_d       = jump_target;
                        state_d    = StBubble;
                    end else if (op_goto) begin
                        pc_d    = jump_target;
                        state_d = StBubble;
                    end else if (pcl_we) begin
                        pc_d    = pcl_target;
                        state_d = StBubble;
                    end else if (skip_taken) begin
                        pc_d    = pc_inc;
                        state_d = StBubble;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
                default: begin
                    state_d = StBubble;
                end
            endcase
        end

        // The depth counter only tracks diagnostics; the stack itself wraps.
        if (stack_push) begin
            if (depth_q == DepthMax) begin
                ovf_d = 1'b1;
            end else begin
                depth_d = depth_q + DepthOne;
            end
        end
        if (stack_pop) begin
            if (depth_q == '0) begin
                unf_d = 1'b1;
            end else begin
                depth_d = depth_q - DepthOne;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StBubble;
            pc_q    <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign pc         = pc_q;
    assign pcl_rdata  = pc_q[7:0];
    assign exec_valid = (state_q == StRun);
    assign stack_data = pc_q;
    assign stack_ovf  = ovf_q;
    assign stack_unf  = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        op_call;
    logic        op_goto;
    logic        op_return;
    logic        skip_taken;
    logic        pcl_we;
    logic [7:0]  pcl_wdata;
    logic [4:0]  pclath;
    logic [10:0] lit_k;
    logic [12:0] stack_top;
    logic [12:0] pc;
    logic [7:0]  pcl_rdata;
    logic        exec_valid;
    logic        stack_push;
    logic        stack_pop;
    logic [12:0] stack_data;
    logic        stack_ovf;
    logic        stack_unf;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(
        .PC_WIDTH (13),
        .LIT_WIDTH(11),
        .TOS_WIDTH(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .op_call   (op_call),
        .op_goto   (op_goto),
        .op_return (op_return),
        .skip_taken(skip_taken),
        .pcl_we    (pcl_we),
        .pcl_wdata (pcl_wdata),
        .pclath    (pclath),
        .lit_k     (lit_k),
        .stack_top (stack_top),
        .pc        (pc),
        .pcl_rdata (pcl_rdata),
        .exec_valid(exec_valid),
        .stack_push(stack_push),
        .stack_pop (stack_pop),
        .stack_data(stack_data),
        .stack_ovf (stack_ovf),
        .stack_unf (stack_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ops();
        op_call    = 1'b0;
        op_goto    = 1'b0;
        op_return  = 1'b0;
        skip_taken = 1'b0;
        pcl_we     = 1'b0;
        pcl_wdata  = 8'h00;
        pclath     = 5'h00;
        lit_k      = 11'h000;
        stack_top  = 13'h0000;
    endtask

    task automatic do_reset();
        clear_ops();
        ce  = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // From RUN with ce=1: GOTO addr-1, then let the bubble advance to addr in RUN.
    task automatic goto_run(input logic [12:0] addr);
        logic [12:0] t;
        t       = addr - 13'h0001;
        op_goto = 1'b1;
        pclath  = {t[12:11], 3'b000};
        lit_k   = t[10:0];
        tick();
        op_goto = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (pc !== 13'h0000) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 13'h0000); end
        checks++; if (exec_valid !== 1'b0) begin errors++; $display("FAIL reset_exec_valid: got %b expected 0", exec_valid); end
        checks++; if (stack_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", stack_ovf); end
        checks++; if (stack_unf !== 1'b0) begin errors++; $display("FAIL reset_unf: got %b expected 0", stack_unf); end
        checks++; if ({stack_push, stack_pop} !== 2'b00) begin errors++; $display("FAIL reset_push_pop: got %b expected 00", {stack_push, stack_pop}); end
    endtask

    task automatic test_sequential();
        do_reset();
        ce = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++; if (pc !== 13'(i)) begin errors++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, pc, 13'(i)); end
            checks++; if (exec_valid !== 1'b1) begin errors++; $display("FAIL seq_exec_valid[%0d]: got %b expected 1", i, exec_valid); end
        end
    endtask

    task automatic test_call_return();
        do_reset();
        ce = 1'b1;
        tick();
        goto_run(13'h0005);
        checks++; if (pc !== 13'h0005) begin errors++; $display("FAIL call_start_pc: got %h expected %h", pc, 13'h0005); end
        op_call = 1'b1;
        pclath  = 5'h18;
        lit_k   = 11'h123;
        #1;
        checks++; if (stack_push !== 1'b1 || stack_pop !== 1'b0) begin errors++; $display("FAIL call_push: got push=%b pop=%b expected push=1 pop=0", stack_push, stack_pop); end
        checks++; if (stack_data !== 13'h0005) begin errors++; $display("FAIL call_stack_data: got %h expected %h", stack_data, 13'h0005); end
        tick();
        op_call = 1'b0;
        checks++; if (pc !== 13'h1923) begin errors++; $display("FAIL call_target: got %h expected %h", pc, 13'h1923); end
        checks++; if (exec_valid !== 1'b0) begin errors++; $display("FAIL call_bubble: got %b expected 0", exec_valid); end
        tick();
        checks++; if (pc !== 13'h1924 || exec_valid !== 1'b1) begin errors++; $display("FAIL call_after_bubble: got pc=%h ev=%b expected pc=1924 ev=1", pc, exec_valid); end
        op_return = 1'b1;
        stack_top = 13'h0005;
        #1;
        checks++; if (stack_pop !== 1'b1 || stack_push !== 1'b0) begin errors++; $display("FAIL ret_pop: got push=%b pop=%b expected push=0 pop=1", stack_push, stack_pop); end
        tick();
        op_return = 1'b0;
        checks++; if (pc !== 13'h0005 || exec_valid !== 1'b0) begin errors++; $display("FAIL ret_target: got pc=%h ev=%b expected pc=0005 ev=0", pc, exec_valid); end
        checks++; if (stack_unf !== 1'b0) begin errors++; $display("FAIL ret_no_unf: got %b expected 0", stack_unf); end
    endtask

    task automatic test_pcl_write();
        do_reset();
        ce = 1'b1;
        tick();
        pcl_we    = 1'b1;
        pcl_wdata = 8'h40;
        pclath    = 5'h0A;
        tick();
        pcl_we = 1'b0;
        checks++; if (pc !== 13'h0A40 || exec_valid !== 1'b0) begin errors++; $display("FAIL pcl_target: got pc=%h ev=%b expected pc=0a40 ev=0", pc, exec_valid); end
        checks++; if (pcl_rdata !== 8'h40) begin errors++; $display("FAIL pcl_rdata: got %h expected %h", pcl_rdata, 8'h40); end
        op_call = 1'b1;
        lit_k   = 11'h7FF;
        #1;
        checks++; if (stack_push !== 1'b0) begin errors++; $display("FAIL bubble_call_push: got %b expected 0", stack_push); end
        tick();
        op_call = 1'b0;
        checks++; if (pc !== 13'h0A41 || exec_valid !== 1'b1) begin errors++; $display("FAIL bubble_call_ignored: got pc=%h ev=%b expected pc=0a41 ev=1", pc, exec_valid); end
    endtask

    task automatic test_priority_skip();
        do_reset();
        ce = 1'b1;
        tick();
        op_return = 1'b1;
        op_call   = 1'b1;
        stack_top = 13'h0ABC;
        #1;
        checks++; if (stack_pop !== 1'b1 || stack_push !== 1'b0) begin errors++; $display("FAIL prio_push_pop: got push=%b pop=%b expected push=0 pop=1", stack_push, stack_pop); end
        tick();
        clear_ops();
        checks++; if (pc !== 13'h0ABC) begin errors++; $display("FAIL prio_pc: got %h expected %h", pc, 13'h0ABC); end
        tick();
        goto_run(13'h0010);
        skip_taken = 1'b1;
        tick();
        skip_taken = 1'b0;
        checks++; if (pc !== 13'h0011 || exec_valid !== 1'b0) begin errors++; $display("FAIL skip_bubble: got pc=%h ev=%b expected pc=0011 ev=0", pc, exec_valid); end
        tick();
        checks++; if (pc !== 13'h0012 || exec_valid !== 1'b1) begin errors++; $display("FAIL skip_resume: got pc=%h ev=%b expected pc=0012 ev=1", pc, exec_valid); end
    endtask

    task automatic test_overflow_underflow();
        do_reset();
        ce = 1'b1;
        tick();
        for (int i = 1; i <= 9; i++) begin
            op_call = 1'b1;
            lit_k   = 11'(11'h100 + i);
            #1;
            checks++; if (stack_push !== 1'b1) begin errors++; $display("FAIL nest_push[%0d]: got %b expected 1", i, stack_push); end
            tick();
            op_call = 1'b0;
            checks++; if (stack_ovf !== (i == 9)) begin errors++; $display("FAIL nest_ovf[%0d]: got %b expected %b", i, stack_ovf, (i == 9)); end
            tick();
        end
        // Reset on an edge where a CALL would otherwise be taken.
        op_call = 1'b1;
        rst     = 1'b1;
        #1;
        checks++; if (stack_push !== 1'b0) begin errors++; $display("FAIL rst_suppress_push: got %b expected 0", stack_push); end
        tick();
        rst     = 1'b0;
        op_call = 1'b0;
        checks++; if (stack_ovf !== 1'b0 || pc !== 13'h0000 || exec_valid !== 1'b0) begin errors++; $display("FAIL rst_clear: got ovf=%b pc=%h ev=%b expected ovf=0 pc=0000 ev=0", stack_ovf, pc, exec_valid); end
        tick();
        op_return = 1'b1;
        tick();
        op_return = 1'b0;
        checks++; if (stack_unf !== 1'b1 || stack_ovf !== 1'b0) begin errors++; $display("FAIL unf_set: got unf=%b ovf=%b expected unf=1 ovf=0", stack_unf, stack_ovf); end
    endtask

    task automatic test_wrap();
        do_reset();
        ce = 1'b1;
        tick();
        goto_run(13'h1FFF);
        checks++; if (pc !== 13'h1FFF) begin errors++; $display("FAIL wrap_start: got %h expected %h", pc, 13'h1FFF); end
        tick();
        checks++; if (pc !== 13'h0000 || exec_valid !== 1'b1) begin errors++; $display("FAIL wrap_pc: got pc=%h ev=%b expected pc=0000 ev=1", pc, exec_valid); end
    endtask

    task automatic test_ce_stall();
        do_reset();
        ce = 1'b1;
        tick();
        goto_run(13'h0020);
        op_call = 1'b1;
        pclath  = 5'h00;
        lit_k   = 11'h055;
        ce      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (stack_push !== 1'b0) begin errors++; $display("FAIL stall_push[%0d]: got %b expected 0", i, stack_push); end
            tick();
            checks++; if (pc !== 13'h0020 || exec_valid !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d]: got pc=%h ev=%b expected pc=0020 ev=1", i, pc, exec_valid); end
        end
        ce = 1'b1;
        #1;
        checks++; if (stack_push !== 1'b1 || stack_data !== 13'h0020) begin errors++; $display("FAIL stall_resume_push: got push=%b data=%h expected push=1 data=0020", stack_push, stack_data); end
        tick();
        op_call = 1'b0;
        checks++; if (pc !== 13'h0055 || exec_valid !== 1'b0) begin errors++; $display("FAIL stall_resume_pc: got pc=%h ev=%b expected pc=0055 ev=0", pc, exec_valid); end
    endtask

    initial begin
        rst = 1'b1;
        ce  = 1'b0;
        clear_ops();
        test_reset();
        test_sequential();
        test_call_return();
        test_pcl_write();
        test_priority_skip();
        test_overflow_underflow();
        test_wrap();
        test_ce_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
